// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the serial shift-register sequencer.
// Imported by the channel interface, the controller and the bench.
package shift_seq_pkg;

   localparam int   DEFAULT_WIDTH = 4;
   localparam logic DIR_RIGHT     = 1'b0;
   localparam logic DIR_LEFT      = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/response channel between a host agent (master) and the sequencer (slave).
// Both channels use valid/ready; the response carries the captured register value.
interface shift_seq_ctrl_if
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 3
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_len;
   logic [WIDTH-1:0] cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_dir, cmd_len, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_len, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer: shifts up to WIDTH command bits into an external shift register, then
// returns its q. Latency len_eff+2 cycles to rsp_valid; a stalled response blocks new commands.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   shift_seq_ctrl_if.slave   bus,
   output logic              shift_en,
   output logic              dir,
   output logic              serial_in,
   input  logic [WIDTH-1:0]  q_in,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             shift_en_q;
   logic             dir_q;
   logic             serial_in_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             busy_q;
   logic [CNT_W-1:0] len_eff;

   // Clamp before counting so the down-counter never has to wrap.
   assign len_eff = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= '0;
         shift_en_q  <= 1'b0;
         dir_q       <= DIR_RIGHT;
         serial_in_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  dir_q  <= bus.cmd_dir;
                  busy_q <= 1'b1;
                  if (len_eff != '0) begin
                     state_q     <= SHIFT;
                     cnt_q       <= len_eff;
                     shift_en_q  <= 1'b1;
                     serial_in_q <= bus.cmd_data[0];
                     data_q      <= bus.cmd_data >> 1;
                  end else begin
                     state_q <= CAPTURE;
                  end
               end
            end
            SHIFT: begin
               // cnt_q counts shift cycles still being presented, including this one.
               if (cnt_q == LEN_ONE) begin
                  state_q     <= CAPTURE;
                  cnt_q       <= '0;
                  shift_en_q  <= 1'b0;
                  serial_in_q <= 1'b0;
               end else begin
                  cnt_q       <= cnt_q - LEN_ONE;
                  serial_in_q <= data_q[0];
                  data_q      <= data_q >> 1;
               end
            end
            CAPTURE: begin
               rsp_data_q  <= q_in;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign shift_en      = shift_en_q;
   assign dir           = dir_q;
   assign serial_in     = serial_in_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed scenarios plus random commands against a
// command-level model of the 4-bit bidirectional shift register.
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             sr_rst;
   logic             shift_en;
   logic             dir;
   logic             serial_in;
   logic             busy;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] model_q;

   int n_checks = 0;
   int n_fail   = 0;

   shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .shift_en  (shift_en),
      .dir       (dir),
      .serial_in (serial_in),
      .q_in      (sr_q),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Environment: the controlled shift register, which the controller's reset does not clear.
   always @(posedge clk) begin
      if (sr_rst)
         sr_q <= '0;
      else if (shift_en)
         sr_q <= (dir == DIR_LEFT) ? {sr_q[WIDTH-2:0], serial_in} : {serial_in, sr_q[WIDTH-1:1]};
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Register value after n bits of data (LSB first) enter from the chosen side.
   function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] q, input logic d,
                                                   input logic [WIDTH-1:0] data, input int n);
      int v = int'(q);
      for (int k = 0; k < n; k++) begin
         if (d == DIR_LEFT) v = ((v * 2) % 16) + int'(data[k]);
         else               v = (v / 2) + 8 * int'(data[k]);
      end
      return v[WIDTH-1:0];
   endfunction

   task automatic drive_noise();
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_dir   = 1'($urandom_range(0, 1));
      bus.cmd_len   = CNT_W'($urandom_range(0, 7));
      bus.cmd_data  = WIDTH'($urandom_range(0, 15));
   endtask

   task automatic run_cmd(input logic d, input logic [CNT_W-1:0] len,
                          input logic [WIDTH-1:0] data, input int hold);
      int               le;
      int               n;
      int               lat;
      logic [WIDTH-1:0] bits;
      logic [WIDTH-1:0] exp_q;
      le    = (int'(len) > WIDTH) ? WIDTH : int'(len);
      exp_q = model_shift(model_q, d, data, le);
      n     = 0;
      lat   = 0;
      bits  = '0;
      @(negedge clk);
      check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = d;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      for (int c = 1; c <= 20; c++) begin
         if (bus.rsp_valid) begin
            lat = c;
            break;
         end
         if (shift_en) begin
            if (n < WIDTH) bits[n] = serial_in;
            n++;
            check_eq("dir_during_shift", 32'(dir), 32'(d));
         end
         check_eq("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
         drive_noise();
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      check_eq("rsp_latency", 32'(lat), 32'(le + 2));
      check_eq("shift_cycles", 32'(n), 32'(le));
      check_eq("serial_bits", 32'(bits), 32'(data & WIDTH'((1 << le) - 1)));
      check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_q));
      check_eq("reg_q", 32'(sr_q), 32'(exp_q));
      for (int i = 0; i < hold; i++) begin
         drive_noise();
         @(negedge clk);
         check_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("hold_rsp_data", 32'(bus.rsp_data), 32'(exp_q));
         check_eq("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         check_eq("hold_shift_en", 32'(shift_en), 32'd0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check_eq("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("post_busy", 32'(busy), 32'd0);
      check_eq("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("post_dir_held", 32'(dir), 32'(d));
      check_eq("post_reg_q", 32'(sr_q), 32'(exp_q));
      model_q = exp_q;
   endtask

   initial begin
      rst           = 1'b1;
      sr_rst        = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      model_q       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      sr_rst = 1'b0;
      check_eq("rst_shift_en", 32'(shift_en), 32'd0);
      check_eq("rst_dir", 32'(dir), 32'd0);
      check_eq("rst_serial_in", 32'(serial_in), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      run_cmd(DIR_RIGHT, 3'd3, 4'b0101, 0);
      check_eq("t2_q", 32'(model_q), 32'hA);
      run_cmd(DIR_LEFT, 3'd3, 4'b0101, 0);
      check_eq("t3_q", 32'(model_q), 32'h5);
      run_cmd(DIR_RIGHT, 3'd0, 4'b1010, 0);
      run_cmd(DIR_RIGHT, 3'd7, 4'b1111, 0);
      check_eq("t4_q", 32'(model_q), 32'hF);
      run_cmd(DIR_LEFT, 3'd2, 4'b0110, 5);

      for (int r = 0; r < 24; r++)
         run_cmd(1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 7)),
                 WIDTH'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

      // Reset lands in the second shift cycle of a 4-bit command.
      @(negedge clk);
      check_eq("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = DIR_RIGHT;
      bus.cmd_len   = 3'd4;
      bus.cmd_data  = 4'b1011;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_shift_en", 32'(shift_en), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      model_q = model_shift(model_q, DIR_RIGHT, 4'b1011, 2);
      check_eq("abort_reg_q", 32'(sr_q), 32'(model_q));
      run_cmd(DIR_LEFT, 3'd4, 4'b1001, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the 4-bit bidirectional serial-in shift register (ports clk, rst, shift_en, dir, serial_in, q).
- Accepts one command per valid/ready handshake: direction, bit count, data bits.
- Drives shift_en/dir/serial_in for exactly the requested number of cycles, then captures the register's q and returns it on a valid/ready response channel.
- Sits between a host/bus agent and the shift register; the parent instantiates both side by side.

Parameters:
WIDTH, 4, width of the controlled shift register and of cmd_data/q_in/rsp_data
CNT_W, 3, width of cmd_len and the internal bit counter; must hold WIDTH (clog2(WIDTH)+1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_dir  input  1  0 = right shift (serial_in enters MSB), 1 = left shift (serial_in enters LSB)
cmd_len  input  CNT_W  number of shifts; 0 allowed; values > WIDTH clamped to WIDTH
cmd_data  input  WIDTH  bits to shift in, cmd_data[0] first
shift_en  output  1  to shift register
dir  output  1  to shift register
serial_in  output  1  to shift register
q_in  input  WIDTH  shift register q, fed back
rsp_valid  output  1  response holds captured q
rsp_ready  input  1  response consumer ready
rsp_data  output  WIDTH  captured q
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst sampled high at an edge): state IDLE; shift_en=0, dir=0, serial_in=0, rsp_valid=0, rsp_data=0, busy=0, counter=0; cmd_ready=1 from the first cycle after rst deasserts. Reset mid-command aborts the command with no response; the shift register keeps whatever shifts already occurred.
- All outputs except cmd_ready (decoded from state) are registered.
- States: IDLE -> SHIFT -> CAPTURE -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge E0, latch dir, data, len_eff=min(cmd_len,WIDTH). If len_eff>0 go to SHIFT, else go to CAPTURE.
- SHIFT: during cycles 1..len_eff after E0, shift_en=1, dir=latched dir, serial_in=data[k] in cycle k+1 (k=0..len_eff-1). The register therefore shifts on exactly len_eff edges. After the last shift cycle, shift_en=0 and serial_in=0; dir holds its value until the next command.
- CAPTURE: one cycle with shift_en=0 so q_in is stable. At the end of the cycle, rsp_data<=q_in.
- RESP: rsp_valid=1 from cycle len_eff+2 after E0. rsp_data is held stable while rsp_valid && !rsp_ready. On rsp_valid&&rsp_ready, go to IDLE; cmd_ready=1 the next cycle.
- Minimum command-to-command spacing: len_eff+3 cycles. No cmd/rsp overlap; cmd_valid is ignored outside IDLE.
- Counter arithmetic is unsigned CNT_W bits. Clamping happens before the count starts; there is no wrap.

Decomposition:
- Package shift_seq_pkg holds: state enum (IDLE, SHIFT, CAPTURE, RESP), localparam DIR_RIGHT=0 / DIR_LEFT=1, and the default WIDTH.
- Single flat module, no sub-module. The shift register is instantiated by the parent and by the bench.

Test Plan:
1. Assert rst for 2 cycles, then deassert -> all outputs 0, cmd_ready=1, busy=0.
2. Register starts at 0000. Send cmd_dir=0, cmd_len=3, cmd_data=0101 -> serial_in 1,0,1 with shift_en high for exactly 3 cycles; q goes 1000, 0100, 1010; rsp_valid at E0+5 with rsp_data=1010.
3. From 1010, send cmd_dir=1, cmd_len=3, cmd_data=0101 -> q goes 0101, 1010, 0101; rsp_data=0101.
4. Send cmd_len=0 -> shift_en never high; rsp_valid at E0+2 with rsp_data equal to current q (0101). Then send cmd_len=7, cmd_data=1111, dir=0 -> exactly 4 shift_en cycles (clamped); rsp_data=1111.
5. Backpressure: hold rsp_ready=0 for 5 cycles while toggling cmd_valid -> rsp_valid and rsp_data stay stable, cmd_ready=0, no new shift_en. Release rsp_ready -> IDLE the next cycle.
6. Assert rst in the 2nd SHIFT cycle of a len=4 command -> after that edge shift_en=0, busy=0, no rsp_valid; q shows exactly 2 shifts; the next command completes normally.
